// File: rtl/pcie_tlp_pkg.sv
// Shared TLP definitions for the PIO completion path: format/type constants,
// completion status, the completion FSM encoding and the byte-count /
// lower-address helpers derived from the first byte enable.
package pcie_tlp_pkg;

  localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
  localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
  localparam logic [4:0] TYPE_CPL       = 5'b01010;
  localparam logic [2:0] CPL_STATUS_SC  = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_HDR     = 2'd2,
    ST_DATA    = 2'd3
  } cpl_state_t;

  // Bytes covered by the first BE, from lowest to highest enabled lane.
  // An all-zero BE still reports one byte.
  function automatic logic [11:0] cpl_byte_count(input logic [3:0] first_be);
    casez (first_be)
      4'b1??1:                   return 12'd4;
      4'b01?1, 4'b1?10:          return 12'd3;
      4'b0011, 4'b0110, 4'b1100: return 12'd2;
      default:                   return 12'd1;
    endcase
  endfunction

  // Byte offset of the first enabled lane inside the DW.
  function automatic logic [1:0] cpl_lower_bits(input logic [3:0] first_be);
    casez (first_be)
      4'b???1: return 2'b00;
      4'b??10: return 2'b01;
      4'b?100: return 2'b10;
      4'b1000: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/pio_cpl_hdr.sv
// Combinational 3DW completion header builder. Produces DW0..DW2 from the
// latched request fields; shared with other completion sources.
module pio_cpl_hdr
  import pcie_tlp_pkg::*;
(
  input  logic        wd,
  input  logic [2:0]  tc,
  input  logic        td,
  input  logic        ep,
  input  logic [1:0]  attr,
  input  logic [15:0] rid,
  input  logic [7:0]  tag,
  input  logic [3:0]  first_be,
  input  logic [4:0]  addr_lo,
  input  logic [15:0] completer_id,
  output logic [31:0] dw0,
  output logic [31:0] dw1,
  output logic [31:0] dw2
);

  // Assemble the three header DWs; a data-less Cpl carries length 0.
  always_comb begin
    dw0 = {1'b0, (wd ? FMT_3DW_DATA : FMT_3DW_NODATA), TYPE_CPL, 1'b0, tc,
           4'b0000, td, ep, attr, 2'b00, (wd ? 10'd1 : 10'd0)};
    dw1 = {completer_id, CPL_STATUS_SC, 1'b0, cpl_byte_count(first_be)};
    dw2 = {rid, tag, 1'b0, addr_lo, cpl_lower_bits(first_be)};
  end

endmodule

// File: rtl/pio_cpl_tx.sv
// PIO completion transmitter: accepts one decoded read, performs the access
// with a fixed read latency, then sends a 2-beat 3DW CplD/Cpl on AXI-S.
// Optional statistics counters are enabled with `define PIO_CPL_STATS_EN.
//
// AXI-S handshake: a beat transfers on a rising edge where tvalid and tready
// are both 1. Once tvalid is raised, tdata/tkeep/tlast and tvalid stay fixed
// until that transfer; tready may toggle freely and never feeds tvalid.
module pio_cpl_tx
  import pcie_tlp_pkg::*;
#(
  parameter int TCQ    = 1,
  parameter int RD_LAT = 1
) (
  input  logic        pcie_clk,
  input  logic        pcie_rst,
  input  logic        req_compl,
  input  logic        req_compl_wd,
  input  logic [2:0]  req_tc,
  input  logic        req_td,
  input  logic        req_ep,
  input  logic [1:0]  req_attr,
  input  logic [9:0]  req_len,
  input  logic [15:0] req_rid,
  input  logic [7:0]  req_tag,
  input  logic [7:0]  req_be,
  input  logic [13:0] req_addr,
  input  logic [15:0] completer_id,
  output logic [13:0] rd_addr,
  output logic [3:0]  rd_be,
  input  logic [31:0] rd_data,
  input  logic        s_axis_tx_tready,
  output logic        s_axis_tx_tvalid,
  output logic [63:0] s_axis_tx_tdata,
  output logic [7:0]  s_axis_tx_tkeep,
  output logic        s_axis_tx_tlast,
  output logic [3:0]  s_axis_tx_tuser,
  output logic        compl_done,
  output cpl_state_t  fsm_state
`ifdef PIO_CPL_STATS_EN
  ,
  output logic [31:0] cpl_count,
  output logic [31:0] stall_count
`endif
);

  cpl_state_t  state_q, state_d;
  logic [2:0]  cnt_q;
  logic        accept;
  logic        wd_q, td_q, ep_q;
  logic [2:0]  tc_q;
  logic [1:0]  attr_q;
  logic [15:0] rid_q;
  logic [7:0]  tag_q;
  logic [31:0] data_q;
  logic [31:0] dw0, dw1, dw2;

  // Length and last BE never shape a 1-DW completion.
  logic unused_inputs;
  assign unused_inputs = ^{req_len, req_be[7:4], (TCQ != 0)};

  assign s_axis_tx_tuser = 4'b0000;
  assign fsm_state       = state_q;

  pio_cpl_hdr u_hdr (
    .wd           (wd_q),
    .tc           (tc_q),
    .td           (td_q),
    .ep           (ep_q),
    .attr         (attr_q),
    .rid          (rid_q),
    .tag          (tag_q),
    .first_be     (rd_be),
    .addr_lo      (rd_addr[4:0]),
    .completer_id (completer_id),
    .dw0          (dw0),
    .dw1          (dw1),
    .dw2          (dw2)
  );

  // FSM state register.
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and AXI-S beat contents; compl_done gates re-sampling of
  // req_compl so a held request is not taken twice.
  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    s_axis_tx_tdata  = 64'h0;
    s_axis_tx_tkeep  = 8'h00;
    s_axis_tx_tlast  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_compl && !compl_done) begin
          accept  = 1'b1;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_HDR;
      end
      ST_HDR: begin
        s_axis_tx_tvalid = 1'b1;
        s_axis_tx_tdata  = {dw1, dw0};
        s_axis_tx_tkeep  = 8'hFF;
        if (s_axis_tx_tready) state_d = ST_DATA;
      end
      ST_DATA: begin
        s_axis_tx_tvalid = 1'b1;
        s_axis_tx_tlast  = 1'b1;
        s_axis_tx_tdata  = wd_q ? {data_q, dw2} : {32'h0, dw2};
        s_axis_tx_tkeep  = wd_q ? 8'hFF : 8'h0F;
        if (s_axis_tx_tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, read-latency counter, read-data capture and done pulse.
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      cnt_q      <= 3'd0;
      rd_addr    <= 14'h0;
      rd_be      <= 4'h0;
      wd_q       <= 1'b0;
      tc_q       <= 3'd0;
      td_q       <= 1'b0;
      ep_q       <= 1'b0;
      attr_q     <= 2'd0;
      rid_q      <= 16'h0;
      tag_q      <= 8'h0;
      data_q     <= 32'h0;
      compl_done <= 1'b0;
    end else begin
      compl_done <= 1'b0;
      if (accept) begin
        rd_addr <= req_addr;
        rd_be   <= req_be[3:0];
        wd_q    <= req_compl_wd;
        tc_q    <= req_tc;
        td_q    <= req_td;
        ep_q    <= req_ep;
        attr_q  <= req_attr;
        rid_q   <= req_rid;
        tag_q   <= req_tag;
        cnt_q   <= 3'(RD_LAT);
      end
      if (state_q == ST_RD_WAIT) begin
        if (cnt_q == 3'd0) data_q <= rd_data;
        else               cnt_q  <= cnt_q - 3'd1;
      end
      if (state_q == ST_DATA && s_axis_tx_tready) compl_done <= 1'b1;
    end
  end

`ifdef PIO_CPL_STATS_EN
  // Completion count wraps; stall count saturates at all-ones.
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      cpl_count   <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (state_q == ST_DATA && s_axis_tx_tready) cpl_count <= cpl_count + 32'd1;
      if (s_axis_tx_tvalid && !s_axis_tx_tready && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pio_cpl_tx.sv
// Bench for pio_cpl_tx: directed and random read completions, an access
// block model that presents read data only in the exact latency cycle, and a
// per-cycle beat scoreboard fed by a field-level TLP model.
module tb_pio_cpl_tx;
  import pcie_tlp_pkg::*;

  localparam int RD_LAT = 3;

  typedef struct packed {
    logic        wd;
    logic [2:0]  tc;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [7:0]  be;
    logic [13:0] addr;
    logic [31:0] data;
    logic [15:0] cid;
  } req_t;

  logic        clk;
  logic        pcie_rst;
  logic        req_compl, req_compl_wd, req_td, req_ep;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic [9:0]  req_len;
  logic [15:0] req_rid, completer_id;
  logic [7:0]  req_tag, req_be;
  logic [13:0] req_addr, rd_addr;
  logic [3:0]  rd_be, s_axis_tx_tuser;
  logic [31:0] rd_data;
  logic        s_axis_tx_tready, s_axis_tx_tvalid, s_axis_tx_tlast, compl_done;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  cpl_state_t  fsm_state;
`ifdef PIO_CPL_STATS_EN
  logic [31:0] cpl_count, stall_count;
`endif

  logic [72:0] exp_q[$];
  bit          done_pend;
  int unsigned m_cpl, m_stall;
  int          n_pass, n_total;

  pio_cpl_tx #(.TCQ(1), .RD_LAT(RD_LAT)) dut (
    .pcie_clk         (clk),
    .pcie_rst         (pcie_rst),
    .req_compl        (req_compl),
    .req_compl_wd     (req_compl_wd),
    .req_tc           (req_tc),
    .req_td           (req_td),
    .req_ep           (req_ep),
    .req_attr         (req_attr),
    .req_len          (req_len),
    .req_rid          (req_rid),
    .req_tag          (req_tag),
    .req_be           (req_be),
    .req_addr         (req_addr),
    .completer_id     (completer_id),
    .rd_addr          (rd_addr),
    .rd_be            (rd_be),
    .rd_data          (rd_data),
    .s_axis_tx_tready (s_axis_tx_tready),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tkeep  (s_axis_tx_tkeep),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tuser  (s_axis_tx_tuser),
    .compl_done       (compl_done),
    .fsm_state        (fsm_state)
`ifdef PIO_CPL_STATS_EN
    ,
    .cpl_count        (cpl_count),
    .stall_count      (stall_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---- reference model: field rules of a 1-DW completion ----
  function automatic int bc_of(input logic [3:0] be);
    int lo, hi;
    lo = -1;
    hi = -1;
    for (int i = 0; i < 4; i++)
      if (be[i]) begin
        if (lo < 0) lo = i;
        hi = i;
      end
    return (lo < 0) ? 1 : (hi - lo + 1);
  endfunction

  function automatic logic [6:0] la_of(input logic [13:0] addr, input logic [3:0] be);
    int lo;
    lo = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
    return {addr[4:0], 2'(lo)};
  endfunction

  function automatic logic [72:0] hdr_beat(input req_t r);
    logic [31:0] dw0, dw1;
    dw0 = {1'b0, (r.wd ? 2'b10 : 2'b00), 5'b01010, 1'b0, r.tc, 4'h0, r.td, r.ep,
           r.attr, 2'b00, (r.wd ? 10'd1 : 10'd0)};
    dw1 = {r.cid, 3'b000, 1'b0, 12'(bc_of(r.be[3:0]))};
    return {1'b0, 8'hFF, dw1, dw0};
  endfunction

  function automatic logic [72:0] data_beat(input req_t r);
    logic [31:0] dw2;
    dw2 = {r.rid, r.tag, 1'b0, la_of(r.addr, r.be[3:0])};
    return r.wd ? {1'b1, 8'hFF, r.data, dw2} : {1'b1, 8'h0F, 32'h0, dw2};
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.wd   = ($urandom_range(0, 3) != 0);
    r.tc   = 3'($urandom);
    r.td   = 1'($urandom);
    r.ep   = 1'($urandom);
    r.attr = 2'($urandom);
    r.rid  = 16'($urandom);
    r.tag  = 8'($urandom);
    r.be   = 8'($urandom);
    r.addr = 14'($urandom);
    r.data = $urandom;
    r.cid  = 16'($urandom);
    return r;
  endfunction

  // ---- scoreboard: every cycle outside reset ----
  always @(negedge clk) begin
    if (pcie_rst) begin
      exp_q.delete();
      done_pend = 1'b0;
      m_cpl     = 0;
      m_stall   = 0;
    end else begin
      chk("compl_done", compl_done, done_pend);
      done_pend = 1'b0;
      chk("tuser", s_axis_tx_tuser, 0);
      if (s_axis_tx_tvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {s_axis_tx_tlast, s_axis_tx_tkeep, s_axis_tx_tdata}, 0);
        end else begin
          chk("beat", {s_axis_tx_tlast, s_axis_tx_tkeep, s_axis_tx_tdata}, exp_q[0]);
          if (s_axis_tx_tready) begin
            if (exp_q[0][72]) begin
              done_pend = 1'b1;
              m_cpl++;
            end
            void'(exp_q.pop_front());
          end else begin
            if (m_stall != 32'hFFFF_FFFF) m_stall++;
          end
        end
      end
    end
  end

  // ---- driver: one request through access, header and data ----
  // Called at posedge+1 with the DUT idle (b2b=0), or at the negedge of the
  // compl_done cycle with req_compl still high (b2b=1).
  task automatic do_req(input req_t r, input bit b2b, input int hs, input int ds,
                        input bit rst_mid);
    exp_q.push_back(hdr_beat(r));
    exp_q.push_back(data_beat(r));
    rd_data      = r.data ^ ($urandom | 32'h1);
    completer_id = r.cid;
    req_compl_wd = r.wd;
    req_tc       = r.tc;
    req_td       = r.td;
    req_ep       = r.ep;
    req_attr     = r.attr;
    req_len      = 10'($urandom);
    req_rid      = r.rid;
    req_tag      = r.tag;
    req_be       = r.be;
    req_addr     = r.addr;
    req_compl    = 1'b1;
    if (b2b) @(posedge clk);
    @(posedge clk); #1;
    chk("rd_addr", rd_addr, r.addr);
    chk("rd_be", rd_be, r.be[3:0]);
    repeat (RD_LAT) begin @(posedge clk); #1; end
    chk("rd_addr_hold", rd_addr, r.addr);
    rd_data = r.data;
    @(posedge clk); #1;
    rd_data = r.data ^ ($urandom | 32'h1);
    s_axis_tx_tready = 1'b0;
    repeat (hs) begin @(posedge clk); #1; end
    s_axis_tx_tready = 1'b1;
    @(posedge clk); #1;
    s_axis_tx_tready = 1'b0;
    if (rst_mid) begin
      pcie_rst  = 1'b1;
      req_compl = 1'b0;
      @(posedge clk); #1;
      pcie_rst = 1'b0;
      @(negedge clk);
      chk("rst_tvalid", s_axis_tx_tvalid, 0);
      chk("rst_state", fsm_state, ST_IDLE);
      chk("rst_no_done", compl_done, 0);
      return;
    end
    repeat (ds) begin @(posedge clk); #1; end
    s_axis_tx_tready = 1'b1;
    @(posedge clk); #1;
    s_axis_tx_tready = 1'b0;
    @(negedge clk);
    chk("done_pulse", compl_done, 1);
    chk("beats_left", exp_q.size(), 0);
  endtask

  task automatic gap(input int n);
    req_compl = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    req_t r;
    bit   b2b;
    n_pass = 0; n_total = 0;
    done_pend = 1'b0; m_cpl = 0; m_stall = 0;
    pcie_rst = 1'b1; req_compl = 1'b0; req_compl_wd = 1'b0; req_tc = 3'd0;
    req_td = 1'b0; req_ep = 1'b0; req_attr = 2'd0; req_len = 10'd0;
    req_rid = 16'h0; req_tag = 8'h0; req_be = 8'h0; req_addr = 14'h0;
    completer_id = 16'h0; rd_data = 32'h0; s_axis_tx_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tvalid", s_axis_tx_tvalid, 0);
    chk("reset_tdata", s_axis_tx_tdata, 0);
    chk("reset_tkeep", s_axis_tx_tkeep, 0);
    chk("reset_tlast", s_axis_tx_tlast, 0);
    chk("reset_done", compl_done, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_rd_be", rd_be, 0);
    chk("reset_state", fsm_state, ST_IDLE);
    @(posedge clk); #1;
    pcie_rst = 1'b0;
    @(posedge clk); #1;

    // Basic CplD; model pinned to hand-computed beats
    r = '0;
    r.wd = 1'b1; r.rid = 16'h0100; r.tag = 8'h05; r.be = 8'h0F;
    r.addr = 14'h1000; r.data = 32'h67452301; r.cid = 16'h0300;
    chk("model_hdr_t1", hdr_beat(r), {1'b0, 8'hFF, 64'h0300_0004_4A00_0001});
    chk("model_data_t1", data_beat(r), {1'b1, 8'hFF, 64'h6745_2301_0100_0500});
    do_req(r, 1'b0, 0, 0, 1'b0);
    gap(2);

    // First BE 1100 at DW 0x2003
    chk("model_bc_1100", bc_of(4'b1100), 2);
    chk("model_la_1100", la_of(14'h2003, 4'b1100), 7'h0E);
    chk("model_bc_1001", bc_of(4'b1001), 4);
    chk("model_bc_0101", bc_of(4'b0101), 3);
    chk("model_bc_0000", bc_of(4'b0000), 1);
    r = rand_req();
    r.wd = 1'b1; r.be = 8'h0C; r.addr = 14'h2003;
    do_req(r, 1'b0, 1, 0, 1'b0);

    // First BE 0010, back-to-back with held req_compl
    chk("model_bc_0010", bc_of(4'b0010), 1);
    chk("model_la_0010", la_of(14'h0000, 4'b0010), 7'h01);
    r = rand_req();
    r.wd = 1'b1; r.be = 8'h02;
    do_req(r, 1'b1, 0, 1, 1'b0);
    gap(1);

    // Long back-pressure in both beats
    r = rand_req();
    do_req(r, 1'b0, 5, 3, 1'b0);

    // Data-less completion, back-to-back
    r = '0;
    r.wd = 1'b0; r.be = 8'h0F; r.data = 32'hDEADBEEF; r.cid = 16'h0300;
    chk("model_dw0_nodata", hdr_beat(r), {1'b0, 8'hFF, 64'h0300_0004_0A00_0000});
    do_req(r, 1'b1, 0, 0, 1'b0);
    gap(1);

    // Reset while the data beat is stalled, then a fresh request
    r = rand_req();
    do_req(r, 1'b0, 2, 0, 1'b1);
    gap(1);
    r = rand_req();
    do_req(r, 1'b0, 0, 2, 1'b0);

    // Random traffic
    b2b = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!b2b) gap($urandom_range(1, 3));
      r = rand_req();
      do_req(r, b2b, $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
      b2b = 1'($urandom_range(0, 1));
    end

`ifdef PIO_CPL_STATS_EN
    chk("cpl_count", cpl_count, m_cpl);
    chk("stall_count", stall_count, m_stall);
`endif
    req_compl = 1'b0;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
